nuc970_err_addr_collect: RTL and testbench

//  Downstream of the NUC970 BCH decoder (Chien search / error-locate stage).

---
 rtl/nuc970_err_addr_collect.sv | 192 +++++++++++++++++++
 tb/tb_nuc970_err_addr_collect.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nuc970_err_addr_collect.sv
// ---------------------------------------------------------------------------
// nuc970_err_addr_collect
//
// Sits after the NUC970 BCH error-locate stage. It turns the per-beat error
// bit stream into a list of absolute error bit positions, one per slot. It
// also flags blocks that cannot be corrected: too many errors, hits in the
// padding area, or (optionally) a count that disagrees with the BMA.
//
// Optional feature macro: NUC970_ERR_CNT_CHECK_EN
//   defined   : when the block ends, found_cnt != latched err_cnt_in sets fail
//   undefined : err_cnt_in is ignored
//
// Ports
//   clk_in      in   1         clock, rising edge
//   rst_n       in   1         asynchronous reset, active low
//   err_in      in   BITS      error bits of the current beat (MSB = lowest position)
//   first_in    in   1         beat 0 of a block (qualified by valid_in)
//   last_in     in   1         final beat of a block (qualified by valid_in)
//   valid_in    in   1         beat qualifier
//   err_cnt_in  in   8         BMA error count, sampled on the first beat
//   rd_idx      in   IDX_W     slot select for pos_out
//   pos_out     out  POS_W     registered slot[rd_idx], 0 when rd_idx >= T
//   found_cnt   out  8         error bits seen this block, saturating at 255
//   busy        out  1         collection in progress (incl. the accepting cycle)
//   done        out  1         one-cycle pulse one cycle after the last beat
//   fail        out  1         uncorrectable / inconsistent block, valid with done
// ---------------------------------------------------------------------------
module nuc970_err_addr_collect #(
   parameter int T         = 4,
   parameter int DATA_BITS = 4288,
   parameter int BITS      = 8,
   parameter int POS_W     = 16,
   localparam int IDX_W    = (T > 1) ? $clog2(T) : 1
) (
   input  logic             clk_in,
   input  logic             rst_n,
   input  logic [BITS-1:0]  err_in,
   input  logic             first_in,
   input  logic             last_in,
   input  logic             valid_in,
   input  logic [7:0]       err_cnt_in,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [POS_W-1:0] pos_out,
   output logic [7:0]       found_cnt,
   output logic             busy,
   output logic             done,
   output logic             fail
);

   localparam int FILL_W = $clog2(T + 1);
   // Wide enough to hold one beat past the end of the codeword, so a padding
   // position can never alias back to a valid one.
   localparam int PB_W = $clog2(DATA_BITS + BITS) + 1;
   localparam logic [PB_W-1:0] DATA_LIM  = PB_W'(DATA_BITS);
   localparam logic [PB_W-1:0] BEAT_STEP = PB_W'(BITS);

   typedef enum logic [1:0] {
      S_IDLE,
      S_COLLECT,
      S_DONE
   } state_t;

   state_t state_q, state_d;

   logic [PB_W-1:0]   base_q, base_d, cur_base;  // position of err_in[BITS-1]
   logic [FILL_W-1:0] fill_q, fill_d;            // number of slots in use
   logic [POS_W-1:0]  slot_q [T];
   logic [POS_W-1:0]  slot_d [T];
   logic [7:0]        found_q, found_d;
   logic              fail_q, fail_d;
   logic [PB_W-1:0]   pos;
   logic [8:0]        sum;

   logic start;  // first beat of a block accepted this cycle
   logic take;   // this cycle's beat is processed

   // A first beat arriving in DONE is dropped: DONE always returns to IDLE.
   assign start = valid_in & first_in & (state_q != S_DONE);
   assign take  = start | (valid_in & (state_q == S_COLLECT));

`ifdef NUC970_ERR_CNT_CHECK_EN
   logic [7:0] err_cnt_q, err_cnt_d;
`else
   logic unused_err_cnt;
   assign unused_err_cnt = ^err_cnt_in;
`endif

   // ---------------------------------------------------------------- FSM
   // NOTE: every combinational output gets a default before the case/if, so no
   // path leaves a variable unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:    if (start) state_d = last_in ? S_DONE : S_COLLECT;
         // A fresh first_in here restarts the block; the datapath clears itself.
         S_COLLECT: if (valid_in & last_in) state_d = S_DONE;
         S_DONE:    state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // ----------------------------------------------------------- datapath
   // NOTE: blocking assignments here are deliberate: fill_d and slot_d are
   // updated bit by bit inside the loop, so each set bit sees the slot
   // chosen by the bit before it within the same cycle.
   always_comb begin
      cur_base = start ? '0 : base_q;
      base_d   = base_q;
      fill_d   = start ? '0 : fill_q;
      fail_d   = start ? 1'b0 : fail_q;
      found_d  = found_q;
      for (int i = 0; i < T; i++) slot_d[i] = start ? '0 : slot_q[i];
`ifdef NUC970_ERR_CNT_CHECK_EN
      err_cnt_d = start ? err_cnt_in : err_cnt_q;
`endif
      sum = {1'b0, (start ? 8'd0 : found_q)};
      pos = '0;

      if (take) begin
         for (int k = 0; k < BITS; k++) begin
            pos = cur_base + PB_W'(k);
            if (err_in[BITS-1-k]) begin
               sum = sum + 9'd1;
               if (pos >= DATA_LIM) begin
                  fail_d = 1'b1;                        // padding hit, not stored
               end else if (int'(fill_d) < T) begin
                  slot_d[IDX_W'(fill_d)] = POS_W'(pos);
                  fill_d = fill_d + FILL_W'(1);
               end else begin
                  fail_d = 1'b1;                        // more than T errors
               end
            end
         end
         found_d = sum[8] ? 8'hFF : sum[7:0];
         // Stop advancing once past the codeword; later bits stay padding.
         base_d  = (cur_base < DATA_LIM) ? cur_base + BEAT_STEP : cur_base;
`ifdef NUC970_ERR_CNT_CHECK_EN
         if (last_in && (found_d != err_cnt_d)) fail_d = 1'b1;
`endif
      end
   end

   // ---------------------------------------------------------- registers
   // NOTE: the slot array is reset like ordinary state: reads after reset must
   // return 0, so it cannot be left to power-up values.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         base_q  <= '0;
         fill_q  <= '0;
         found_q <= '0;
         fail_q  <= 1'b0;
         for (int i = 0; i < T; i++) slot_q[i] <= '0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         fill_q  <= fill_d;
         found_q <= found_d;
         fail_q  <= fail_d;
         for (int i = 0; i < T; i++) slot_q[i] <= slot_d[i];
      end
   end

`ifdef NUC970_ERR_CNT_CHECK_EN
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) err_cnt_q <= '0;
      else        err_cnt_q <= err_cnt_d;
   end
`endif

   // ------------------------------------------------------------ read port
   generate
      if ((1 << IDX_W) > T) begin : g_rd_guard
         always_ff @(posedge clk_in or negedge rst_n) begin
            if (!rst_n)                pos_out <= '0;
            else if (int'(rd_idx) < T) pos_out <= slot_q[rd_idx];
            else                       pos_out <= '0;
         end
      end else begin : g_rd_direct
         always_ff @(posedge clk_in or negedge rst_n) begin
            if (!rst_n) pos_out <= '0;
            else        pos_out <= slot_q[rd_idx];
         end
      end
   endgenerate

   assign found_cnt = found_q;
   assign fail      = fail_q;
   assign done      = (state_q == S_DONE);
   assign busy      = (state_q == S_COLLECT) | start;

endmodule

// File: tb/tb_nuc970_err_addr_collect.sv
// ---------------------------------------------------------------------------
// tb_nuc970_err_addr_collect
//
// Drives whole blocks of error beats into nuc970_err_addr_collect. The
// expected slots, found_cnt and fail come from a block-level model that
// walks the beat list and applies the position rule directly.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_nuc970_err_addr_collect;

   localparam int T         = 4;
   localparam int DATA_BITS = 4288;
   localparam int BITS      = 8;
   localparam int POS_W     = 16;
`ifdef NUC970_ERR_CNT_CHECK_EN
   localparam bit CHECK = 1'b1;
`else
   localparam bit CHECK = 1'b0;
`endif

   logic             clk_in = 1'b0;
   logic             rst_n;
   logic [BITS-1:0]  err_in;
   logic             first_in, last_in, valid_in;
   logic [7:0]       err_cnt_in;
   logic [1:0]       rd_idx;
   logic [POS_W-1:0] pos_out;
   logic [7:0]       found_cnt;
   logic             busy, done, fail;

   nuc970_err_addr_collect #(
      .T(T), .DATA_BITS(DATA_BITS), .BITS(BITS), .POS_W(POS_W)
   ) dut (
      .clk_in(clk_in), .rst_n(rst_n), .err_in(err_in), .first_in(first_in),
      .last_in(last_in), .valid_in(valid_in), .err_cnt_in(err_cnt_in),
      .rd_idx(rd_idx), .pos_out(pos_out), .found_cnt(found_cnt),
      .busy(busy), .done(done), .fail(fail)
   );

   always #5 clk_in = ~clk_in;

   int n_vec = 0;
   int n_bad = 0;

   logic [7:0] blk[$];        // beats of the block under test
   int         exp_slot[T];
   int         exp_found;
   bit         exp_fail;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic clear_blk(input int len);
      blk.delete();
      repeat (len) blk.push_back(8'h00);
   endtask

   task automatic set_pos(input int p);
      logic [7:0] b;
      b = blk[p / BITS];
      b[BITS-1-(p % BITS)] = 1'b1;
      blk[p / BITS] = b;
   endtask

   // Block-level reference: list every set bit as beat*BITS+k, keep the first
   // T in-range ones, fail on padding, on more than T, or on a count mismatch.
   task automatic build_model(input logic [7:0] errcnt);
      int total;
      bit pad;
      int hits[$];
      total = 0;
      pad   = 1'b0;
      for (int n = 0; n < blk.size(); n++) begin
         for (int k = 0; k < BITS; k++) begin
            if (blk[n][BITS-1-k]) begin
               total++;
               if (n * BITS + k >= DATA_BITS) pad = 1'b1;
               else hits.push_back(n * BITS + k);
            end
         end
      end
      exp_found = (total > 255) ? 255 : total;
      exp_fail  = pad || (total > T) || (CHECK && (exp_found != int'(errcnt)));
      for (int i = 0; i < T; i++) exp_slot[i] = (i < hits.size()) ? hits[i] : 0;
   endtask

   task automatic idle_inputs();
      valid_in   = 1'b0;
      first_in   = 1'b0;
      last_in    = 1'b0;
      err_in     = '0;
      err_cnt_in = '0;
   endtask

   // Drive blk as one block, with optional random valid_in gaps carrying junk.
   task automatic send_beats(input logic [7:0] errcnt, input int max_gap, input bit with_last,
                             inout bit saw_done, inout bit busy_bad);
      for (int n = 0; n < blk.size(); n++) begin
         int g;
         g = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
         repeat (g) begin
            @(negedge clk_in);
            if (done) saw_done = 1'b1;
            if (n > 0 && !busy) busy_bad = 1'b1;
            valid_in   = 1'b0;
            err_in     = 8'($urandom);
            first_in   = 1'($urandom);
            last_in    = 1'($urandom);
            err_cnt_in = 8'($urandom);
         end
         @(negedge clk_in);
         if (done) saw_done = 1'b1;
         if (n > 0 && !busy) busy_bad = 1'b1;
         valid_in   = 1'b1;
         err_in     = blk[n];
         first_in   = (n == 0);
         last_in    = with_last && (n == blk.size() - 1);
         err_cnt_in = (n == 0) ? errcnt : 8'($urandom);
         if (n == 0) begin
            #1;
            if (!busy) busy_bad = 1'b1;
         end
      end
   endtask

   task automatic read_slots(input string name);
      for (int i = 0; i < T; i++) begin
         @(negedge clk_in);
         rd_idx = 2'(i);
         @(negedge clk_in);
         check($sformatf("%s:slot%0d", name, i), 32'(pos_out), 32'(exp_slot[i]));
      end
   endtask

   task automatic finish_block(input string name, input bit saw_done, input bit busy_bad);
      @(negedge clk_in);
      check({name, ":done_early"}, 32'(saw_done), 0);
      check({name, ":busy_in_blk"}, 32'(busy_bad), 0);
      check({name, ":done"}, 32'(done), 1);
      check({name, ":busy_at_done"}, 32'(busy), 0);
      check({name, ":found_cnt"}, 32'(found_cnt), 32'(exp_found));
      check({name, ":fail"}, 32'(fail), 32'(exp_fail));
      idle_inputs();
      @(negedge clk_in);
      check({name, ":done_width"}, 32'(done), 0);
      check({name, ":fail_hold"}, 32'(fail), 32'(exp_fail));
      read_slots(name);
   endtask

   task automatic run_block(input string name, input logic [7:0] errcnt, input int max_gap);
      bit sd, bb;
      sd = 1'b0;
      bb = 1'b0;
      build_model(errcnt);
      send_beats(errcnt, max_gap, 1'b1, sd, bb);
      finish_block(name, sd, bb);
   endtask

   initial begin
      bit sd, bb;
      rst_n  = 1'b0;
      rd_idx = '0;
      idle_inputs();
      repeat (3) @(negedge clk_in);
      #1;
      check("rst:done", 32'(done), 0);
      check("rst:busy", 32'(busy), 0);
      check("rst:fail", 32'(fail), 0);
      check("rst:found_cnt", 32'(found_cnt), 0);
      check("rst:pos_out", 32'(pos_out), 0);
      rst_n = 1'b1;
      for (int i = 0; i < T; i++) exp_slot[i] = 0;
      read_slots("rst");

      // All-zero block.
      clear_blk(536);
      run_block("zero", 8'd0, 0);

      // First and last codeword bits.
      clear_blk(536);
      blk[0] = 8'h80; blk[535] = 8'h01;
      run_block("ends", 8'd2, 0);

      // Eight errors in one beat: overflow, first four kept.
      clear_blk(536);
      blk[10] = 8'hFF;
      run_block("overflow", 8'd4, 0);

      // Single error at 100 with a wrong BMA count.
      clear_blk(536);
      set_pos(100);
      run_block("cnt_mismatch", 8'd3, 0);

      // Same two errors as "ends", now with valid_in gaps.
      clear_blk(536);
      blk[0] = 8'h80; blk[535] = 8'h01;
      run_block("gaps", 8'd2, 3);

      // A set bit in the padding beat after the codeword.
      clear_blk(537);
      set_pos(29); blk[536] = 8'h80;
      run_block("padding", 8'd2, 0);

      // first_in and last_in on the same beat.
      clear_blk(1);
      blk[0] = 8'h41;
      run_block("one_beat", 8'd2, 0);

      // found_cnt saturation.
      clear_blk(40);
      foreach (blk[i]) blk[i] = 8'hFF;
      run_block("saturate", 8'd255, 0);

      // Restart: a new first_in abandons a 200-beat block without a done.
      sd = 1'b0; bb = 1'b0;
      clear_blk(200);
      blk[5] = 8'h20;
      send_beats(8'd1, 1, 1'b0, sd, bb);
      clear_blk(536);
      blk[20] = 8'h81; blk[400] = 8'h02;
      build_model(8'd3);
      send_beats(8'd3, 1, 1'b1, sd, bb);
      finish_block("restart", sd, bb);

      // Reset in the middle of a block.
      sd = 1'b0; bb = 1'b0;
      clear_blk(300);
      blk[2] = 8'hF0;
      send_beats(8'd4, 0, 1'b0, sd, bb);
      @(negedge clk_in);
      idle_inputs();
      rst_n = 1'b0;
      #1;
      check("midrst:found_cnt", 32'(found_cnt), 0);
      check("midrst:fail", 32'(fail), 0);
      check("midrst:busy", 32'(busy), 0);
      check("midrst:done", 32'(done), 0);
      repeat (2) @(negedge clk_in);
      rst_n = 1'b1;
      sd = 1'b0;
      repeat (20) begin
         @(negedge clk_in);
         if (done) sd = 1'b1;
      end
      check("midrst:no_done", 32'(sd), 0);
      for (int i = 0; i < T; i++) exp_slot[i] = 0;
      read_slots("midrst");

      // Random blocks.
      for (int r = 0; r < 10; r++) begin
         int len, nerr, cnt;
         logic [7:0] ec;
         len  = $urandom_range(536, 1);
         nerr = $urandom_range(6, 0);
         clear_blk(len);
         for (int e = 0; e < nerr; e++) set_pos($urandom_range(len * BITS - 1, 0));
         cnt = 0;
         foreach (blk[i]) cnt += $countones(blk[i]);
         ec = $urandom_range(1, 0) ? 8'(cnt) : 8'($urandom_range(6, 0));
         run_block($sformatf("rand%0d", r), ec, $urandom_range(2, 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
